vram_touch_painter: RTL and testbench
=====================================

Name: vram_touch_painter

Overview:
- Sits between the FT6206 touch controller output and the VRAM write port of the block RAM.
- Owns the single VRAM write port.
- On reset or on request, sweeps the whole frame to CLEAR_COLOR.
- Otherwise converts each valid touch (x,y) into a clipped square brush stamp of VRAM writes, one pixel per cycle.

Parameters:
WIDTH, 240, display width in pixels (x range 0..WIDTH-1)
HEIGHT, 320, display height in pixels (y range 0..HEIGHT-1)
BRUSH_R, 1, brush radius; stamp is (2*BRUSH_R+1)^2 pixels
CLEAR_COLOR, 16'hFFFF, RGB565 colour written by clear sweep
AW, $clog2(WIDTH*HEIGHT), VRAM address width (17 at defaults)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clear_req  in  1  one-cycle request to re-clear the frame
touch_valid  in  1  touch0.valid from touch controller
touch_x  in  9  touch0.x
touch_y  in  9  touch0.y
paint_color  in  16  RGB565 brush colour, sampled at touch capture
vram_wr_ena  out  1  VRAM write enable
vram_wr_addr  out  AW  VRAM write address = y*WIDTH + x
vram_wr_data  out  16  VRAM write data
clearing  out  1  high while the clear sweep is in progress
busy  out  1  high in S_CLEAR or S_PAINT

Behaviour:
- Reset and clock: rst is synchronous, active-high; clk is the clock. All outputs are registered.
- Values while rst is high: state=S_CLEAR, clear counter=0, vram_wr_ena=0, vram_wr_addr=0, vram_wr_data=CLEAR_COLOR, clearing=1, busy=1.
- S_CLEAR:
  - On the k-th cycle after rst deasserts (k=0..WIDTH*HEIGHT-1), outputs are wr_ena=1, addr=k, data=CLEAR_COLOR.
  - After addr WIDTH*HEIGHT-1 is presented, the next cycle is S_IDLE with wr_ena=0 and clearing=0.
  - The counter never wraps.
  - touch_valid and clear_req are ignored in this state.
- S_IDLE:
  - clear_req=1 → S_CLEAR with counter=0; first clear write appears the next cycle.
  - Else if touch_valid=1 and touch_x<WIDTH and touch_y<HEIGHT, capture x, y and paint_color, then go to S_PAINT.
  - An out-of-range touch is dropped; state stays S_IDLE.
  - clear_req and a touch on the same edge: clear wins and the touch is dropped.
- S_PAINT:
  - Iterate dy=-R..+R (outer loop) and dx=-R..+R (inner loop), where R=BRUSH_R; one pixel per cycle.
  - Writes appear in cycles E+1 .. E+(2R+1)^2, where E is the capture edge.
  - Pixel (x+dx, y+dy) inside [0,WIDTH-1]x[0,HEIGHT-1]: wr_ena=1, addr=(y+dy)*WIDTH+(x+dx), data=captured colour.
  - Clipped pixel: wr_ena=0; the cycle is still consumed, giving fixed stamp latency.
  - Use signed arithmetic at least 11 bits wide for x+dx and y+dy, so 0-1 reads as negative and is never taken as a large unsigned value.
  - After the last stamp cycle → S_IDLE. A new touch can be captured on the first S_IDLE edge.
  - clear_req during S_PAINT aborts the stamp immediately: no further paint writes; S_CLEAR starts at addr 0 the next cycle.
- Inputs are assumed stable only when sampled. Touch inputs change asynchronously to stamps, so captured values are used for the whole stamp.
- The multiply by WIDTH is by a constant; it may be pipelined, provided the output timing above is unchanged.
- Outputs: busy=(state!=S_IDLE); clearing=(state==S_CLEAR).

Optional Feature:
- Macro: VRAM_TOUCH_PAINTER_DEDUP_EN.
- Defined:
  - Hold a last_x/last_y/last_valid register, set on each capture.
  - A touch in S_IDLE whose x,y equal last_x,last_y with last_valid=1 is dropped (no stamp).
  - A touch_valid=0 cycle in S_IDLE, or any entry to S_CLEAR, clears last_valid.
- Not defined: every valid in-range touch in S_IDLE starts a stamp, including repeats of the same point.

Test Plan:
- Clear sweep (WIDTH*HEIGHT=76800 writes): release rst, hold other inputs 0 → exactly 76800 consecutive wr_ena=1 cycles, addr 0..76799, data 16'hFFFF, then clearing=0 and busy=0.
- Interior stamp: after clear, touch (10,20), colour 16'hF800 held 1 cycle → 9 writes on cycles E+1..E+9:
  - addrs 4569, 4570, 4571, 4809, 4810, 4811, 5049, 5050, 5051
  - all data 16'hF800
- Corner clipping: touch (0,0) → 9-cycle stamp with exactly 4 writes (addrs 0, 1, 240, 241) and 5 cycles of wr_ena=0. Touch (239,319) → writes at addrs 76558, 76559, 76798, 76799 only.
- Out-of-range and priority cases:
  - Touch (240,5) → no writes, busy stays 0.
  - clear_req with touch (50,50) on the same edge → clear sweep starts, no paint writes.
- Abort: clear_req on the 4th stamp cycle of touch (100,100) → exactly 3 paint writes, then a clear write at addr 0 the next cycle; no writes lost or duplicated in the sweep.
- Dedup (with VRAM_TOUCH_PAINTER_DEDUP_EN): hold touch (10,20) valid for 50 cycles → one 9-pixel stamp only. Without the macro → repeated stamps, one starting every 10 cycles.

Source files
------------

// File: rtl/vram_touch_painter.sv
// Owns the VRAM write port. Sweeps the frame to CLEAR_COLOR after reset or on request, and stamps a
// clipped square brush at each accepted touch. The optional macro VRAM_TOUCH_PAINTER_DEDUP_EN drops repeated touches.
module vram_touch_painter #(
   parameter int          WIDTH       = 240,
   parameter int          HEIGHT      = 320,
   parameter int          BRUSH_R     = 1,
   parameter logic [15:0] CLEAR_COLOR = 16'hFFFF,
   parameter int          AW          = $clog2(WIDTH*HEIGHT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_req,
   input  logic          touch_valid,
   input  logic [8:0]    touch_x,
   input  logic [8:0]    touch_y,
   input  logic [15:0]   paint_color,
   output logic          vram_wr_ena,
   output logic [AW-1:0] vram_wr_addr,
   output logic [15:0]   vram_wr_data,
   output logic          clearing,
   output logic          busy
);

   // state   | meaning
   // S_CLEAR | sweeping CLEAR_COLOR over every pixel, one address per cycle
   // S_IDLE  | waiting for clear_req or an in-range touch
   // S_PAINT | emitting the (2R+1)^2 brush stamp, one pixel per cycle
   localparam logic [1:0] S_CLEAR = 2'd0;
   localparam logic [1:0] S_IDLE  = 2'd1;
   localparam logic [1:0] S_PAINT = 2'd2;

   localparam int CW   = 12;
   localparam int SPAN = 2*BRUSH_R + 1;
   localparam int IW   = $clog2(SPAN + 1);

   localparam logic [IW-1:0]        I_LAST   = IW'(SPAN - 1);
   localparam logic [AW-1:0]        PIX_LAST = AW'(WIDTH*HEIGHT - 1);
   localparam logic [AW-1:0]        W_A      = AW'(WIDTH);
   localparam logic signed [CW-1:0] W_S      = CW'(WIDTH);
   localparam logic signed [CW-1:0] H_S      = CW'(HEIGHT);
   localparam logic signed [CW-1:0] R_S      = CW'(BRUSH_R);

   logic [1:0]           state_q, state_d;
   logic [AW-1:0]        cnt_q, cnt_d;
   logic signed [CW-1:0] x_q, x_d, y_q, y_d;
   logic [15:0]          col_q, col_d;
   logic [IW-1:0]        ix_q, ix_d, iy_q, iy_d;
   logic                 ena_q, ena_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [15:0]          data_q, data_d;
   logic                 clearing_q, clearing_d;
   logic                 busy_q, busy_d;

   logic signed [CW-1:0] tx_s, ty_s, px_s, py_s;
   logic [AW-1:0]        px_a, py_a, paint_addr;
   logic                 touch_ok, pix_ok, dup, capture;

   assign tx_s     = signed'(CW'(touch_x));
   assign ty_s     = signed'(CW'(touch_y));
   assign touch_ok = (tx_s < W_S) && (ty_s < H_S);

   // Signed brush offsets so that a coordinate of 0-1 clips instead of wrapping.
   assign px_s   = x_q + signed'(CW'(ix_q)) - R_S;
   assign py_s   = y_q + signed'(CW'(iy_q)) - R_S;
   assign pix_ok = !px_s[CW-1] && (px_s < W_S) && !py_s[CW-1] && (py_s < H_S);

   assign px_a       = AW'(px_s[CW-2:0]);
   assign py_a       = AW'(py_s[CW-2:0]);
   assign paint_addr = py_a * W_A + px_a;

   assign capture = (state_q == S_IDLE) && !clear_req && touch_valid && touch_ok && !dup;

`ifdef VRAM_TOUCH_PAINTER_DEDUP_EN
   logic [8:0] last_x_q, last_y_q;
   logic       last_valid_q;

   assign dup = last_valid_q && (touch_x == last_x_q) && (touch_y == last_y_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         last_x_q     <= '0;
         last_y_q     <= '0;
         last_valid_q <= 1'b0;
      end else if (state_d == S_CLEAR) begin
         last_valid_q <= 1'b0;
      end else if (capture) begin
         last_x_q     <= touch_x;
         last_y_q     <= touch_y;
         last_valid_q <= 1'b1;
      end else if (state_q == S_IDLE && !touch_valid) begin
         last_valid_q <= 1'b0;
      end
   end
`else
   assign dup = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      x_d        = x_q;
      y_d        = y_q;
      col_d      = col_q;
      ix_d       = ix_q;
      iy_d       = iy_q;
      ena_d      = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      clearing_d = (state_q == S_CLEAR);
      busy_d     = (state_q != S_IDLE);

      case (state_q)
         S_CLEAR: begin
            ena_d  = 1'b1;
            addr_d = cnt_q;
            data_d = CLEAR_COLOR;
            if (cnt_q == PIX_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         S_IDLE: begin
            if (clear_req) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end else if (capture) begin
               state_d = S_PAINT;
               x_d     = tx_s;
               y_d     = ty_s;
               col_d   = paint_color;
               ix_d    = '0;
               iy_d    = '0;
            end
         end
         S_PAINT: begin
            if (clear_req) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end else begin
               // Clipped pixels still take their cycle so stamp latency is fixed.
               ena_d  = pix_ok;
               addr_d = paint_addr;
               data_d = col_q;
               if (ix_q == I_LAST) begin
                  ix_d = '0;
                  if (iy_q == I_LAST) begin
                     state_d = S_IDLE;
                  end else begin
                     iy_d = iy_q + IW'(1);
                  end
               end else begin
                  ix_d = ix_q + IW'(1);
               end
            end
         end
         default: begin
            state_d = S_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_CLEAR;
         cnt_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         col_q      <= '0;
         ix_q       <= '0;
         iy_q       <= '0;
         ena_q      <= 1'b0;
         addr_q     <= '0;
         data_q     <= CLEAR_COLOR;
         clearing_q <= 1'b1;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         col_q      <= col_d;
         ix_q       <= ix_d;
         iy_q       <= iy_d;
         ena_q      <= ena_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         clearing_q <= clearing_d;
         busy_q     <= busy_d;
      end
   end

   assign vram_wr_ena  = ena_q;
   assign vram_wr_addr = addr_q;
   assign vram_wr_data = data_q;
   assign clearing     = clearing_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_vram_touch_painter.sv
// Directed bench: a full-size painter for the sweep and stamp geometry, and an 8x6 painter
// for clear-priority and abort cases where the whole re-clear sweep fits in a few cycles.
module tb_vram_touch_painter;

   localparam int AW  = 17;
   localparam int SAW = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, clear_req, touch_valid;
   logic [8:0]    touch_x, touch_y;
   logic [15:0]   paint_color;
   logic          vram_wr_ena, clearing, busy;
   logic [AW-1:0] vram_wr_addr;
   logic [15:0]   vram_wr_data;

   logic           s_rst, s_clear_req, s_touch_valid;
   logic [8:0]     s_touch_x, s_touch_y;
   logic [15:0]    s_paint_color;
   logic           s_ena, s_clearing, s_busy;
   logic [SAW-1:0] s_addr;
   logic [15:0]    s_data;

   vram_touch_painter dut (
      .clk(clk), .rst(rst), .clear_req(clear_req), .touch_valid(touch_valid),
      .touch_x(touch_x), .touch_y(touch_y), .paint_color(paint_color),
      .vram_wr_ena(vram_wr_ena), .vram_wr_addr(vram_wr_addr), .vram_wr_data(vram_wr_data),
      .clearing(clearing), .busy(busy)
   );

   vram_touch_painter #(.WIDTH(8), .HEIGHT(6), .BRUSH_R(1), .CLEAR_COLOR(16'h5A5A)) dut_s (
      .clk(clk), .rst(s_rst), .clear_req(s_clear_req), .touch_valid(s_touch_valid),
      .touch_x(s_touch_x), .touch_y(s_touch_y), .paint_color(s_paint_color),
      .vram_wr_ena(s_ena), .vram_wr_addr(s_addr), .vram_wr_data(s_data),
      .clearing(s_clearing), .busy(s_busy)
   );

   int n_chk = 0;
   int n_pass = 0;

   logic        rec_ena  [9];
   int          rec_addr [9];
   logic [15:0] rec_data [9];
   int          ea [9];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle touch, then record the nine stamp cycles while the inputs carry unrelated values.
   task automatic stamp(input int x, input int y, input logic [15:0] col);
      touch_x = 9'(x);
      touch_y = 9'(y);
      paint_color = col;
      touch_valid = 1'b1;
      tick();
      touch_valid = 1'b0;
      touch_x = 9'd123;
      touch_y = 9'd45;
      paint_color = 16'h0F0F;
      for (int i = 0; i < 9; i++) begin
         tick();
         rec_ena[i]  = vram_wr_ena;
         rec_addr[i] = int'(vram_wr_addr);
         rec_data[i] = vram_wr_data;
      end
   endtask

   task automatic check_stamp(input string tag, input logic [8:0] mask, input int a [9],
                              input logic [15:0] col);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("%s_ena%0d", tag, i), 32'(rec_ena[i]), 32'(mask[i]));
         if (mask[i]) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(rec_addr[i]), 32'(a[i]));
            chk($sformatf("%s_data%0d", tag, i), 32'(rec_data[i]), 32'(col));
         end
      end
      tick();
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   // Full 48-pixel sweep of the small painter; optionally pokes clear_req and a touch mid-sweep.
   task automatic sweep_s(input string tag, input bit poke);
      int bad = 0;
      for (int k = 0; k < 48; k++) begin
         if (poke && k == 10) begin
            s_clear_req = 1'b1;
            s_touch_valid = 1'b1;
            s_touch_x = 9'd2;
            s_touch_y = 9'd2;
         end
         if (poke && k == 12) begin
            s_clear_req = 1'b0;
            s_touch_valid = 1'b0;
         end
         tick();
         if (s_ena !== 1'b1 || s_addr !== SAW'(k) || s_data !== 16'h5A5A || s_clearing !== 1'b1)
            bad++;
      end
      chk({tag, "_sweep_bad"}, 32'(bad), 32'd0);
      tick();
      chk({tag, "_end_ena"}, 32'(s_ena), 32'd0);
      chk({tag, "_end_busy"}, 32'(s_busy), 32'd0);
   endtask

   initial begin
      int bad, nw, ns, last_start;
      rst = 1'b1; clear_req = 1'b0; touch_valid = 1'b0;
      touch_x = '0; touch_y = '0; paint_color = '0;
      s_rst = 1'b1; s_clear_req = 1'b0; s_touch_valid = 1'b0;
      s_touch_x = '0; s_touch_y = '0; s_paint_color = '0;

      repeat (3) tick();
      chk("rst_ena", 32'(vram_wr_ena), 32'd0);
      chk("rst_addr", 32'(vram_wr_addr), 32'd0);
      chk("rst_data", 32'(vram_wr_data), 32'hFFFF);
      chk("rst_clearing", 32'(clearing), 32'd1);
      chk("rst_busy", 32'(busy), 32'd1);

      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 76800; k++) begin
         tick();
         if (vram_wr_ena !== 1'b1 || vram_wr_addr !== AW'(k) || vram_wr_data !== 16'hFFFF ||
             clearing !== 1'b1 || busy !== 1'b1)
            bad++;
      end
      chk("sweep_bad", 32'(bad), 32'd0);
      tick();
      chk("sweep_end_ena", 32'(vram_wr_ena), 32'd0);
      chk("sweep_end_clearing", 32'(clearing), 32'd0);
      chk("sweep_end_busy", 32'(busy), 32'd0);

      stamp(10, 20, 16'hF800);
      ea = '{4569, 4570, 4571, 4809, 4810, 4811, 5049, 5050, 5051};
      check_stamp("interior", 9'h1FF, ea, 16'hF800);

      stamp(0, 0, 16'h001F);
      ea = '{0, 0, 0, 0, 0, 1, 0, 240, 241};
      check_stamp("corner00", 9'h1B0, ea, 16'h001F);

      stamp(239, 319, 16'h07E0);
      ea = '{76558, 76559, 0, 76798, 76799, 0, 0, 0, 0};
      check_stamp("corner_br", 9'h01B, ea, 16'h07E0);

      touch_x = 9'd240; touch_y = 9'd5; touch_valid = 1'b1;
      tick();
      touch_x = 9'd5; touch_y = 9'd320;
      tick();
      touch_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (vram_wr_ena !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("oor_activity", 32'(bad), 32'd0);

      touch_x = 9'd10; touch_y = 9'd20; paint_color = 16'h07E0; touch_valid = 1'b1;
      nw = 0; ns = 0; last_start = -1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (vram_wr_ena === 1'b1) begin
            nw++;
            if (vram_wr_addr === AW'(4569)) begin
               ns++;
               last_start = i;
            end
         end
      end
      touch_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (vram_wr_ena === 1'b1) nw++;
      end
`ifdef VRAM_TOUCH_PAINTER_DEDUP_EN
      chk("hold_writes", 32'(nw), 32'd9);
      chk("hold_stamps", 32'(ns), 32'd1);
      chk("hold_last_start", 32'(last_start), 32'd1);
`else
      chk("hold_writes", 32'(nw), 32'd45);
      chk("hold_stamps", 32'(ns), 32'd5);
      chk("hold_last_start", 32'(last_start), 32'd41);
`endif

      touch_x = 9'd100; touch_y = 9'd100; paint_color = 16'h1234; touch_valid = 1'b1;
      tick();
      touch_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("abort_ena%0d", i), 32'(vram_wr_ena), 32'd1);
         chk($sformatf("abort_addr%0d", i), 32'(vram_wr_addr), 32'(23859 + i));
         chk($sformatf("abort_data%0d", i), 32'(vram_wr_data), 32'h1234);
      end
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      chk("abort_gap_ena", 32'(vram_wr_ena), 32'd0);
      bad = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (vram_wr_ena !== 1'b1 || vram_wr_addr !== AW'(k) || vram_wr_data !== 16'hFFFF ||
             clearing !== 1'b1)
            bad++;
      end
      chk("abort_sweep_start_bad", 32'(bad), 32'd0);

      s_rst = 1'b0;
      sweep_s("s_init", 1'b0);

      s_clear_req = 1'b1; s_touch_valid = 1'b1;
      s_touch_x = 9'd3; s_touch_y = 9'd3; s_paint_color = 16'hABCD;
      tick();
      s_clear_req = 1'b0; s_touch_valid = 1'b0;
      chk("s_prio_ena", 32'(s_ena), 32'd0);
      sweep_s("s_prio", 1'b1);

      s_touch_x = 9'd3; s_touch_y = 9'd3; s_paint_color = 16'hABCD; s_touch_valid = 1'b1;
      tick();
      s_touch_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("s_abort_ena%0d", i), 32'(s_ena), 32'd1);
         chk($sformatf("s_abort_addr%0d", i), 32'(s_addr), 32'(18 + i));
         chk($sformatf("s_abort_data%0d", i), 32'(s_data), 32'hABCD);
      end
      s_clear_req = 1'b1;
      tick();
      s_clear_req = 1'b0;
      chk("s_abort_gap_ena", 32'(s_ena), 32'd0);
      sweep_s("s_abort", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
